// File: rtl/ifm_line_writer.sv
// ----------------------------------------------------------------------------
// ifm_line_writer
//
// Write side of the 4-bank IFM line-buffer ring. Words from the DMA stream
// are written into BRAM bank wr_ptr, one row of ROW_WORDS words per bank.
// When a bank's row is complete, ifm_bram_full[bank] is raised. Banks are
// filled round-robin 0->1->2->3->0. The row reader frees banks in the same
// order with height_hs pulses.
//
// Optional feature macro: IFM_WR_STATUS_EN
//   When defined, adds the err_underrun and occupancy status outputs.
//
// Ports
//   clk            in   1           rising-edge clock
//   rst_na         in   1           asynchronous active-low reset
//   frame_clr      in   1           synchronous pulse: drop the frame, empty the ring
//   s_data         in   RAM_WIDTH   stream word
//   s_valid        in   1           stream word valid
//   s_ready        out  1           writer accepts a word (transfer = s_valid & s_ready)
//   height_hs      in   1           reader finished its current bank
//   bram_we        out  4           one-hot per-bank write enable
//   bram_addr      out  ADDR_W      write address shared by all banks
//   bram_din       out  RAM_WIDTH   write data shared by all banks
//   ifm_bram_full  out  4           bank k holds a complete, unread row
//   err_underrun   out  1           (IFM_WR_STATUS_EN) sticky: release of an empty bank
//   occupancy      out  3           (IFM_WR_STATUS_EN) number of full banks, 0..4
// ----------------------------------------------------------------------------
module ifm_line_writer #(
    parameter int RAM_WIDTH = 64,
    parameter int ROW_WORDS = 13,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_na,
    input  logic                 frame_clr,
    input  logic [RAM_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 height_hs,
    output logic [3:0]           bram_we,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [RAM_WIDTH-1:0] bram_din,
    output logic [3:0]           ifm_bram_full
`ifdef IFM_WR_STATUS_EN
    ,
    output logic                 err_underrun,
    output logic [2:0]           occupancy
`endif
);

    // A bank must be able to hold a whole row.
    if ((2 ** ADDR_W) < ROW_WORDS) begin : g_bad_addr_w
        $error("ifm_line_writer: 2**ADDR_W must be >= ROW_WORDS");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WORDS - 1);

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   count;
    logic [ADDR_W-1:0]   count_nxt;
    logic [1:0]          wr_ptr;
    logic [1:0]          wr_ptr_nxt;
    logic [1:0]          wr_ptr_inc;
    logic [1:0]          rd_ptr;
    logic [1:0]          rd_ptr_nxt;
    logic                set_pend;
    logic                set_pend_nxt;
    logic [1:0]          set_bank;
    logic [1:0]          set_bank_nxt;
    logic [3:0]          clr_mask;
    logic [3:0]          set_mask;
    logic [3:0]          full_nxt;
    logic [3:0]          we_nxt;
    logic                xfer;
    logic                last_word;

    assign s_ready    = (state == FILL);
    assign xfer       = s_valid & s_ready;
    assign last_word  = (count == LAST_ADDR);
    assign wr_ptr_inc = wr_ptr + 2'd1;

    // Next-state and next-value logic.
    // The full flag of a finished bank is set through set_pend, one cycle
    // after its last write strobe, so the BRAM write has landed before any
    // reader can see the flag.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        wr_ptr_nxt   = wr_ptr;
        set_pend_nxt = 1'b0;
        set_bank_nxt = set_bank;
        we_nxt       = 4'b0000;

        clr_mask   = height_hs ? (4'b0001 << rd_ptr) : 4'b0000;
        set_mask   = set_pend  ? (4'b0001 << set_bank) : 4'b0000;
        full_nxt   = (ifm_bram_full & ~clr_mask) | set_mask;
        // The reader rotates unconditionally, even over an empty bank.
        rd_ptr_nxt = height_hs ? (rd_ptr + 2'd1) : rd_ptr;

        case (state)
            FILL: begin
                if (xfer) begin
                    we_nxt = 4'b0001 << wr_ptr;
                    if (last_word) begin
                        count_nxt    = '0;
                        wr_ptr_nxt   = wr_ptr_inc;
                        set_pend_nxt = 1'b1;
                        set_bank_nxt = wr_ptr;
                        // Look at the next bank after this cycle's release so
                        // a coincident height_hs avoids a needless WAIT.
                        if (full_nxt[wr_ptr_inc]) begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!ifm_bram_full[wr_ptr]) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

`ifdef IFM_WR_STATUS_EN
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction
`endif

    // State, pointers and write-port registers.
    always_ff @(posedge clk or negedge rst_na) begin
        if (!rst_na) begin
            state         <= FILL;
            count         <= '0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            set_pend      <= 1'b0;
            set_bank      <= 2'd0;
            bram_we       <= 4'b0000;
            bram_addr     <= '0;
            bram_din      <= '0;
            ifm_bram_full <= 4'b0000;
        end else if (frame_clr) begin
            // Abandon the frame: any partial row is dropped without a flag.
            state         <= FILL;
            count         <= '0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            set_pend      <= 1'b0;
            set_bank      <= 2'd0;
            bram_we       <= 4'b0000;
            bram_addr     <= '0;
            bram_din      <= '0;
            ifm_bram_full <= 4'b0000;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            set_pend      <= set_pend_nxt;
            set_bank      <= set_bank_nxt;
            bram_we       <= we_nxt;
            ifm_bram_full <= full_nxt;
            // Address and data hold their last values between transfers.
            if (xfer) begin
                bram_addr <= count;
                bram_din  <= s_data;
            end
        end
    end

`ifdef IFM_WR_STATUS_EN
    // Status registers; occupancy is taken from the next flag value so it
    // tracks ifm_bram_full in the same cycle.
    always_ff @(posedge clk or negedge rst_na) begin
        if (!rst_na) begin
            err_underrun <= 1'b0;
            occupancy    <= 3'd0;
        end else if (frame_clr) begin
            err_underrun <= 1'b0;
            occupancy    <= 3'd0;
        end else begin
            if (height_hs && !ifm_bram_full[rd_ptr]) begin
                err_underrun <= 1'b1;
            end
            occupancy <= popcount4(full_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_ifm_line_writer.sv
// ----------------------------------------------------------------------------
// tb_ifm_line_writer
// Directed testbench for ifm_line_writer. Each scenario task drives the
// stream/reader inputs and compares the write port and flags against
// hand-computed values. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_ifm_line_writer;

    logic        clk = 1'b0;
    logic        rst_na;
    logic        frame_clr;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        height_hs;
    logic [3:0]  bram_we;
    logic [3:0]  bram_addr;
    logic [63:0] bram_din;
    logic [3:0]  ifm_bram_full;
`ifdef IFM_WR_STATUS_EN
    logic        err_underrun;
    logic [2:0]  occupancy;
`endif

    int total = 0;
    int bad   = 0;

    ifm_line_writer #(
        .RAM_WIDTH(64),
        .ROW_WORDS(13),
        .ADDR_W(4)
    ) dut (
        .clk(clk),
        .rst_na(rst_na),
        .frame_clr(frame_clr),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .height_hs(height_hs),
        .bram_we(bram_we),
        .bram_addr(bram_addr),
        .bram_din(bram_din),
        .ifm_bram_full(ifm_bram_full)
`ifdef IFM_WR_STATUS_EN
        ,
        .err_underrun(err_underrun),
        .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ring();
        frame_clr = 1'b1;
        s_valid   = 1'b0;
        height_hs = 1'b0;
        tick();
        frame_clr = 1'b0;
    endtask

    // Stream n words back-to-back (no checking), then drop s_valid.
    task automatic push_words(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 64'(i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_na = 1'b1;
        #2 rst_na = 1'b0;
        #2;
        total++; if (bram_we !== 4'b0000) begin bad++; $display("FAIL rst_we act=%b exp=%b", bram_we, 4'b0000); end
        total++; if (bram_addr !== 4'd0) begin bad++; $display("FAIL rst_addr act=%0d exp=0", bram_addr); end
        total++; if (bram_din !== 64'd0) begin bad++; $display("FAIL rst_din act=%h exp=0", bram_din); end
        total++; if (ifm_bram_full !== 4'b0000) begin bad++; $display("FAIL rst_full act=%b exp=0000", ifm_bram_full); end
        tick();
        tick();
        rst_na = 1'b1;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready act=%b exp=1", s_ready); end
        total++; if (bram_we !== 4'b0000) begin bad++; $display("FAIL rst_we_idle act=%b exp=0000", bram_we); end
`ifdef IFM_WR_STATUS_EN
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun act=%b exp=0", err_underrun); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ act=%0d exp=0", occupancy); end
`endif
    endtask

    task automatic test_fill();
        logic [3:0]  ea;
        logic [63:0] ed;
        clr_ring();
        for (int i = 0; i < 13; i++) begin
            ea      = 4'(i);
            ed      = 64'hA5A5_0000_0000_0000 | 64'(i);
            s_valid = 1'b1;
            s_data  = ed;
            tick();
            total++; if (bram_we !== 4'b0001) begin bad++; $display("FAIL fill_we[%0d] act=%b exp=0001", i, bram_we); end
            total++; if (bram_addr !== ea) begin bad++; $display("FAIL fill_addr[%0d] act=%0d exp=%0d", i, bram_addr, ea); end
            total++; if (bram_din !== ed) begin bad++; $display("FAIL fill_din[%0d] act=%h exp=%h", i, bram_din, ed); end
            total++; if (ifm_bram_full !== 4'b0000) begin bad++; $display("FAIL fill_full_early[%0d] act=%b exp=0000", i, ifm_bram_full); end
        end
        s_valid = 1'b0;
        tick();
        total++; if (ifm_bram_full !== 4'b0001) begin bad++; $display("FAIL fill_full act=%b exp=0001", ifm_bram_full); end
        total++; if (bram_we !== 4'b0000) begin bad++; $display("FAIL fill_we_idle act=%b exp=0000", bram_we); end
        total++; if (bram_addr !== 4'd12) begin bad++; $display("FAIL fill_addr_hold act=%0d exp=12", bram_addr); end
        s_valid = 1'b1;
        s_data  = 64'h1111_2222_3333_4444;
        tick();
        s_valid = 1'b0;
        total++; if (bram_we !== 4'b0010) begin bad++; $display("FAIL fill_next_we act=%b exp=0010", bram_we); end
        total++; if (bram_addr !== 4'd0) begin bad++; $display("FAIL fill_next_addr act=%0d exp=0", bram_addr); end
    endtask

    task automatic test_ring_full();
        logic [3:0] ew;
        logic [3:0] ea;
        clr_ring();
        for (int i = 0; i < 52; i++) begin
            ew      = 4'b0001 << (i / 13);
            ea      = 4'(i % 13);
            s_valid = 1'b1;
            s_data  = 64'hC000 + 64'(i);
            tick();
            total++; if (bram_we !== ew || bram_addr !== ea) begin bad++; $display("FAIL ring_wr[%0d] we=%b addr=%0d exp we=%b addr=%0d", i, bram_we, bram_addr, ew, ea); end
            if (i == 13 || i == 26 || i == 39) begin
                total++; if (ifm_bram_full !== 4'((1 << (i / 13)) - 1)) begin bad++; $display("FAIL ring_full[%0d] act=%b exp=%b", i, ifm_bram_full, 4'((1 << (i / 13)) - 1)); end
`ifdef IFM_WR_STATUS_EN
                total++; if (occupancy !== 3'(i / 13)) begin bad++; $display("FAIL ring_occ[%0d] act=%0d exp=%0d", i, occupancy, i / 13); end
`endif
            end
        end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ring_ready_wait act=%b exp=0", s_ready); end
        // s_valid stays high while the ring is full: nothing may be written.
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bram_we !== 4'b0000) begin bad++; $display("FAIL ring_we_blocked[%0d] act=%b exp=0000", k, bram_we); end
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ring_ready_blocked[%0d] act=%b exp=0", k, s_ready); end
        end
        total++; if (ifm_bram_full !== 4'b1111) begin bad++; $display("FAIL ring_full4 act=%b exp=1111", ifm_bram_full); end
`ifdef IFM_WR_STATUS_EN
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL ring_occ4 act=%0d exp=4", occupancy); end
`endif
        height_hs = 1'b1;
        s_data    = 64'hD00D;
        tick();
        height_hs = 1'b0;
        total++; if (ifm_bram_full !== 4'b1110) begin bad++; $display("FAIL ring_release act=%b exp=1110", ifm_bram_full); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ring_ready_same act=%b exp=0", s_ready); end
`ifdef IFM_WR_STATUS_EN
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL ring_occ3 act=%0d exp=3", occupancy); end
`endif
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ring_ready_back act=%b exp=1", s_ready); end
        total++; if (bram_we !== 4'b0000) begin bad++; $display("FAIL ring_we_resume0 act=%b exp=0000", bram_we); end
        tick();
        s_valid = 1'b0;
        total++; if (bram_we !== 4'b0001 || bram_addr !== 4'd0) begin bad++; $display("FAIL ring_resume we=%b addr=%0d exp we=0001 addr=0", bram_we, bram_addr); end
        total++; if (bram_din !== 64'hD00D) begin bad++; $display("FAIL ring_resume_din act=%h exp=d00d", bram_din); end
    endtask

    task automatic test_collision();
        clr_ring();
        push_words(13, 64'hE000);
        push_words(12, 64'hE100);
        total++; if (ifm_bram_full !== 4'b0001) begin bad++; $display("FAIL col_pre act=%b exp=0001", ifm_bram_full); end
        s_valid   = 1'b1;
        s_data    = 64'hE10C;
        height_hs = 1'b1;
        tick();
        s_valid   = 1'b0;
        height_hs = 1'b0;
        total++; if (bram_we !== 4'b0010 || bram_addr !== 4'd12) begin bad++; $display("FAIL col_last we=%b addr=%0d exp we=0010 addr=12", bram_we, bram_addr); end
        total++; if (ifm_bram_full !== 4'b0000) begin bad++; $display("FAIL col_mid act=%b exp=0000", ifm_bram_full); end
        tick();
        total++; if (ifm_bram_full !== 4'b0010) begin bad++; $display("FAIL col_post act=%b exp=0010", ifm_bram_full); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL col_ready act=%b exp=1", s_ready); end
        push_words(1, 64'hE200);
        total++; if (bram_we !== 4'b0100 || bram_addr !== 4'd0) begin bad++; $display("FAIL col_wrptr we=%b addr=%0d exp we=0100 addr=0", bram_we, bram_addr); end
        height_hs = 1'b1;
        tick();
        height_hs = 1'b0;
        total++; if (ifm_bram_full !== 4'b0000) begin bad++; $display("FAIL col_rdptr act=%b exp=0000", ifm_bram_full); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic [63:0] last_d;
        logic [3:0]  last_a;
        logic [3:0]  ew;
        logic [63:0] ed;
        int          n;
        int          c;
        pat    = 16'b1011_0010_1101_0110;
        n      = 0;
        c      = 0;
        last_d = 64'd0;
        last_a = 4'd0;
        clr_ring();
        while (n < 26 && c < 200) begin
            s_valid = pat[c % 16];
            ed      = 64'hB000_0000 + 64'(n);
            s_data  = s_valid ? ed : 64'hDEAD_BEEF;
            tick();
            if (s_valid) begin
                ew = 4'b0001 << (n / 13);
                total++; if (bram_we !== ew || bram_addr !== 4'(n % 13) || bram_din !== ed) begin bad++; $display("FAIL bp_xfer[%0d] we=%b addr=%0d din=%h exp we=%b addr=%0d din=%h", n, bram_we, bram_addr, bram_din, ew, n % 13, ed); end
                last_a = 4'(n % 13);
                last_d = ed;
                n++;
            end else begin
                total++; if (bram_we !== 4'b0000 || bram_addr !== last_a || bram_din !== last_d) begin bad++; $display("FAIL bp_idle[%0d] we=%b addr=%0d din=%h exp we=0000 addr=%0d din=%h", c, bram_we, bram_addr, bram_din, last_a, last_d); end
            end
            c++;
        end
        s_valid = 1'b0;
        total++; if (n != 26) begin bad++; $display("FAIL bp_budget transfers=%0d exp=26", n); end
        tick();
        total++; if (ifm_bram_full !== 4'b0011) begin bad++; $display("FAIL bp_full act=%b exp=0011", ifm_bram_full); end
    endtask

    task automatic test_abort();
        // Synchronous frame_clr at count=6 in bank 2.
        clr_ring();
        push_words(32, 64'hF000);
        total++; if (ifm_bram_full !== 4'b0011) begin bad++; $display("FAIL abort_pre act=%b exp=0011", ifm_bram_full); end
        frame_clr = 1'b1;
        s_valid   = 1'b1;
        s_data    = 64'hFFFF;
        tick();
        frame_clr = 1'b0;
        s_valid   = 1'b0;
        total++; if (ifm_bram_full !== 4'b0000 || bram_we !== 4'b0000) begin bad++; $display("FAIL abort_clr full=%b we=%b exp 0000/0000", ifm_bram_full, bram_we); end
        total++; if (bram_addr !== 4'd0 || bram_din !== 64'd0) begin bad++; $display("FAIL abort_port addr=%0d din=%h exp 0/0", bram_addr, bram_din); end
        push_words(1, 64'hF100);
        total++; if (bram_we !== 4'b0001 || bram_addr !== 4'd0) begin bad++; $display("FAIL abort_next we=%b addr=%0d exp we=0001 addr=0", bram_we, bram_addr); end
        tick();
        total++; if (ifm_bram_full !== 4'b0000) begin bad++; $display("FAIL abort_noflag act=%b exp=0000", ifm_bram_full); end
        // Same case with the asynchronous reset asserted mid-cycle.
        clr_ring();
        push_words(32, 64'hF200);
        total++; if (ifm_bram_full !== 4'b0011) begin bad++; $display("FAIL rstab_pre act=%b exp=0011", ifm_bram_full); end
        #2 rst_na = 1'b0;
        #1;
        total++; if (ifm_bram_full !== 4'b0000 || bram_we !== 4'b0000 || bram_addr !== 4'd0) begin bad++; $display("FAIL rstab_async full=%b we=%b addr=%0d exp 0000/0000/0", ifm_bram_full, bram_we, bram_addr); end
        tick();
        rst_na = 1'b1;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstab_ready act=%b exp=1", s_ready); end
        push_words(1, 64'hF300);
        total++; if (bram_we !== 4'b0001 || bram_addr !== 4'd0 || bram_din !== 64'hF300) begin bad++; $display("FAIL rstab_next we=%b addr=%0d din=%h exp we=0001 addr=0 din=f300", bram_we, bram_addr, bram_din); end
    endtask

`ifdef IFM_WR_STATUS_EN
    task automatic test_status();
        clr_ring();
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL st_clear act=%b exp=0", err_underrun); end
        height_hs = 1'b1;
        tick();
        height_hs = 1'b0;
        total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL st_set act=%b exp=1", err_underrun); end
        push_words(13, 64'h5000);
        tick();
        total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL st_sticky act=%b exp=1", err_underrun); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL st_occ act=%0d exp=1", occupancy); end
        clr_ring();
        total++; if (err_underrun !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL st_frameclr underrun=%b occ=%0d exp 0/0", err_underrun, occupancy); end
    endtask
`endif

    initial begin
        rst_na    = 1'b1;
        frame_clr = 1'b0;
        s_data    = 64'd0;
        s_valid   = 1'b0;
        height_hs = 1'b0;
        test_reset();
        test_fill();
        test_ring_full();
        test_collision();
        test_backpressure();
        test_abort();
`ifdef IFM_WR_STATUS_EN
        test_status();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
